// File: rtl/memoria_instrucao_sinc.sv
// Synchronous instruction memory with a programming write port and a fixed-latency fetch pipeline.
// Latency: a response appears exactly LATENCY cycles after a fetch is accepted. Back-to-back fetches return in order.
// Backpressure: fetch_ready is low while prog_en is high. Flush or reset drops every fetch still in flight.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   fetch_req, pc, fetch_ready   fetch request handshake
//   flush                        drops all in-flight fetches
//   instr_valid, instrucao       one-cycle response strobe and the fetched word
//   fault                        response status: 00 ok, 01 out of range, 10 misaligned
//   prog_en, prog_we             programming mode and write enable
//   prog_addr, prog_data         programming write address and data
module memoria_instrucao_sinc #(
    parameter int DEPTH     = 64,
    parameter int PC_W      = 64,
    parameter int BYTE_ADDR = 0,
    parameter int LATENCY   = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_req,
    input  logic [PC_W-1:0] pc,
    output logic            fetch_ready,
    input  logic            flush,
    output logic            instr_valid,
    output logic [31:0]     instrucao,
    output logic [1:0]      fault,
    input  logic            prog_en,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [31:0]     prog_data
);

    // ROM contents start at zero and survive reset, so this array has no reset branch.
    logic [31:0] rom [DEPTH] = '{default: '0};

    logic [PC_W-1:0] word_idx;
    logic            misaligned;
    logic            out_of_range;
    logic            accept;
    logic [31:0]     resp_dat;
    logic [1:0]      resp_flt;

    // Pipeline stages. Stage 0 is loaded at the accept edge, and stage LATENCY-1 drives the outputs.
    logic            stg_vld [LATENCY];
    logic [31:0]     stg_dat [LATENCY];
    logic [1:0]      stg_flt [LATENCY];

    assign fetch_ready = !prog_en;
    assign accept      = fetch_req && fetch_ready;

    // The full-width index is compared against DEPTH, so large PCs never alias onto low words.
    assign word_idx     = (BYTE_ADDR != 0) ? (pc >> 2) : pc;
    assign misaligned   = (BYTE_ADDR != 0) && (pc[1:0] != 2'b00);
    assign out_of_range = (word_idx >= PC_W'(DEPTH));

    // Misalignment outranks out-of-range. Any faulted fetch returns a NOP.
    always_comb begin
        resp_dat = rom[word_idx[AW-1:0]];
        resp_flt = 2'b00;
        if (misaligned) begin
            resp_dat = '0;
            resp_flt = 2'b10;
        end else if (out_of_range) begin
            resp_dat = '0;
            resp_flt = 2'b01;
        end
    end

    // The write uses a non-blocking assignment. A read of the same word at the same
    // edge therefore captures the pre-write value (read-before-write). Data is read
    // at acceptance, so later writes never change a fetch that is already in flight.
    always_ff @(posedge clk) begin
        if (prog_en && prog_we) begin
            rom[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_vld[i] <= 1'b0;
                stg_dat[i] <= '0;
                stg_flt[i] <= 2'b00;
            end
        end else if (flush) begin
            // A fetch accepted in the flush cycle is dropped together with the rest.
            for (int i = 0; i < LATENCY; i++) begin
                stg_vld[i] <= 1'b0;
                stg_dat[i] <= '0;
                stg_flt[i] <= 2'b00;
            end
        end else begin
            stg_vld[0] <= accept;
            stg_dat[0] <= accept ? resp_dat : 32'h0;
            stg_flt[0] <= accept ? resp_flt : 2'b00;
            for (int i = 1; i < LATENCY; i++) begin
                stg_vld[i] <= stg_vld[i-1];
                stg_dat[i] <= stg_dat[i-1];
                stg_flt[i] <= stg_flt[i-1];
            end
        end
    end

    // Gate the outputs so that idle cycles always present a zero instruction and zero fault.
    assign instr_valid = stg_vld[LATENCY-1];
    assign instrucao   = instr_valid ? stg_dat[LATENCY-1] : 32'h0;
    assign fault       = instr_valid ? stg_flt[LATENCY-1] : 2'b00;

endmodule

// File: tb/tb_memoria_instrucao_sinc.sv
// Directed bench for memoria_instrucao_sinc.
// Instance 0: default parameters. Instance 1: BYTE_ADDR=1. Instance 2: LATENCY=3.
// All inputs are driven 1 time unit after a rising edge, and outputs are checked there too.
module tb_memoria_instrucao_sinc;

    logic        clk;
    logic        rst_n;
    logic        fetch_req   [3];
    logic [63:0] pc          [3];
    logic        flush       [3];
    logic        prog_en     [3];
    logic        prog_we     [3];
    logic [5:0]  prog_addr   [3];
    logic [31:0] prog_data   [3];
    logic        fetch_ready [3];
    logic        instr_valid [3];
    logic [31:0] instrucao   [3];
    logic [1:0]  fault       [3];

    int errors = 0;
    int checks = 0;

    memoria_instrucao_sinc #(.DEPTH(64), .PC_W(64), .BYTE_ADDR(0), .LATENCY(1)) u0 (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req[0]), .pc(pc[0]),
        .fetch_ready(fetch_ready[0]), .flush(flush[0]), .instr_valid(instr_valid[0]),
        .instrucao(instrucao[0]), .fault(fault[0]), .prog_en(prog_en[0]),
        .prog_we(prog_we[0]), .prog_addr(prog_addr[0]), .prog_data(prog_data[0])
    );

    memoria_instrucao_sinc #(.DEPTH(64), .PC_W(64), .BYTE_ADDR(1), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req[1]), .pc(pc[1]),
        .fetch_ready(fetch_ready[1]), .flush(flush[1]), .instr_valid(instr_valid[1]),
        .instrucao(instrucao[1]), .fault(fault[1]), .prog_en(prog_en[1]),
        .prog_we(prog_we[1]), .prog_addr(prog_addr[1]), .prog_data(prog_data[1])
    );

    memoria_instrucao_sinc #(.DEPTH(64), .PC_W(64), .BYTE_ADDR(0), .LATENCY(3)) u2 (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req[2]), .pc(pc[2]),
        .fetch_ready(fetch_ready[2]), .flush(flush[2]), .instr_valid(instr_valid[2]),
        .instrucao(instrucao[2]), .fault(fault[2]), .prog_en(prog_en[2]),
        .prog_we(prog_we[2]), .prog_addr(prog_addr[2]), .prog_data(prog_data[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic resp(input int i, input string tag, input logic v, input logic [31:0] d,
                        input logic [1:0] f);
        chk({tag, "_valid"}, 64'(instr_valid[i]), 64'(v));
        chk({tag, "_instr"}, 64'(instrucao[i]), 64'(d));
        chk({tag, "_fault"}, 64'(fault[i]), 64'(f));
    endtask

    task automatic prog(input int i, input logic [5:0] a, input logic [31:0] d);
        prog_en[i]   = 1'b1;
        prog_we[i]   = 1'b1;
        prog_addr[i] = a;
        prog_data[i] = d;
        tick();
        prog_en[i]   = 1'b0;
        prog_we[i]   = 1'b0;
    endtask

    task automatic fetch(input int i, input logic [63:0] p);
        fetch_req[i] = 1'b1;
        pc[i]        = p;
    endtask

    task automatic idle(input int i);
        fetch_req[i] = 1'b0;
    endtask

    // Single LATENCY=1 fetch: present, take the edge, then check the response.
    task automatic fetch1(input int i, input logic [63:0] p, input string tag, input logic [31:0] d,
                          input logic [1:0] f);
        fetch(i, p);
        tick();
        idle(i);
        resp(i, tag, 1'b1, d, f);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_req[i] = 1'b0; pc[i] = '0; flush[i] = 1'b0; prog_en[i] = 1'b0;
            prog_we[i] = 1'b0; prog_addr[i] = '0; prog_data[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        resp(0, "reset", 1'b0, 32'h0, 2'b00);
        chk("reset_ready", 64'(fetch_ready[0]), 64'd1);
        rst_n = 1'b1;

        // ---------------- instance 0: defaults ----------------
        prog_en[0] = 1'b1;
        #1;
        chk("progen_ready", 64'(fetch_ready[0]), 64'd0);
        prog(0, 6'd1, 32'h0070_0083);
        prog(0, 6'd0, 32'hDEAD_BEEF);
        // A write strobe without programming mode must not land in the ROM.
        prog_we[0] = 1'b1; prog_addr[0] = 6'd3; prog_data[0] = 32'h0000_1234;
        tick();
        prog_we[0] = 1'b0;

        fetch1(0, 64'd1, "pc1", 32'h0070_0083, 2'b00);
        tick();
        resp(0, "idle", 1'b0, 32'h0, 2'b00);

        fetch(0, 64'd0);
        tick();
        fetch(0, 64'd1);
        resp(0, "b2b0", 1'b1, 32'hDEAD_BEEF, 2'b00);
        tick();
        idle(0);
        resp(0, "b2b1", 1'b1, 32'h0070_0083, 2'b00);

        fetch1(0, 64'd64, "pc64", 32'h0, 2'b01);
        fetch1(0, 64'h8000_0000_0000_0000, "pc2p63", 32'h0, 2'b01);
        fetch1(0, 64'd3, "we_no_en", 32'h0, 2'b00);

        prog_en[0] = 1'b1;
        fetch(0, 64'd1);
        tick();
        prog_en[0] = 1'b0;
        idle(0);
        resp(0, "progen_ign", 1'b0, 32'h0, 2'b00);

        // ---------------- instance 1: byte addressing ----------------
        prog(1, 6'd2, 32'hCAFE_F00D);
        fetch1(1, 64'd8, "byte8", 32'hCAFE_F00D, 2'b00);
        fetch1(1, 64'd6, "byte6", 32'h0, 2'b10);
        fetch1(1, 64'd256, "byte256", 32'h0, 2'b01);
        fetch1(1, 64'd257, "byte257", 32'h0, 2'b10);
        fetch1(1, 64'd4, "byte4_init", 32'h0, 2'b00);

        // ---------------- instance 2: LATENCY=3 ----------------
        prog(2, 6'd0, 32'hA000_0000);
        prog(2, 6'd1, 32'hA000_0001);
        prog(2, 6'd2, 32'hA000_0002);
        prog(2, 6'd5, 32'h5555_5555);

        fetch(2, 64'd0); tick(); resp(2, "l3_c1", 1'b0, 32'h0, 2'b00);
        fetch(2, 64'd1); tick(); resp(2, "l3_c2", 1'b0, 32'h0, 2'b00);
        fetch(2, 64'd2); tick(); resp(2, "l3_c3", 1'b1, 32'hA000_0000, 2'b00);
        idle(2);         tick(); resp(2, "l3_c4", 1'b1, 32'hA000_0001, 2'b00);
        tick();          resp(2, "l3_c5", 1'b1, 32'hA000_0002, 2'b00);
        tick();          resp(2, "l3_c6", 1'b0, 32'h0, 2'b00);

        // Flush lands in the cycle of the third fetch, so no response may appear.
        fetch(2, 64'd0); tick(); resp(2, "fl_c1", 1'b0, 32'h0, 2'b00);
        fetch(2, 64'd1); tick(); resp(2, "fl_c2", 1'b0, 32'h0, 2'b00);
        fetch(2, 64'd2); flush[2] = 1'b1; tick(); resp(2, "fl_c3", 1'b0, 32'h0, 2'b00);
        flush[2] = 1'b0;
        fetch(2, 64'd1); tick(); resp(2, "afl_c1", 1'b0, 32'h0, 2'b00);
        idle(2);         tick(); resp(2, "afl_c2", 1'b0, 32'h0, 2'b00);
        tick();          resp(2, "afl_c3", 1'b1, 32'hA000_0001, 2'b00);
        tick();          resp(2, "afl_c4", 1'b0, 32'h0, 2'b00);

        // Overwrite rom[5] while a fetch of it is in flight: the old word comes back.
        fetch(2, 64'd5); tick(); idle(2);
        prog_en[2] = 1'b1; prog_we[2] = 1'b1; prog_addr[2] = 6'd5; prog_data[2] = 32'hBBBB_BBBB;
        tick();
        resp(2, "rbw_c2", 1'b0, 32'h0, 2'b00);
        prog_en[2] = 1'b0; prog_we[2] = 1'b0;
        tick();
        resp(2, "rbw_old", 1'b1, 32'h5555_5555, 2'b00);
        fetch(2, 64'd5); tick(); idle(2); tick(); tick();
        resp(2, "rbw_new", 1'b1, 32'hBBBB_BBBB, 2'b00);

        // Reset with two fetches in flight.
        fetch(2, 64'd0); tick();
        fetch(2, 64'd1); tick();
        idle(2);
        rst_n = 1'b0;
        #1;
        resp(2, "rst_imm", 1'b0, 32'h0, 2'b00);
        tick();
        rst_n = 1'b1;
        tick(); resp(2, "rst_r1", 1'b0, 32'h0, 2'b00);
        tick(); resp(2, "rst_r2", 1'b0, 32'h0, 2'b00);
        tick(); resp(2, "rst_r3", 1'b0, 32'h0, 2'b00);

        fetch(2, 64'd5); tick(); idle(2); tick(); tick();
        resp(2, "rst_keep5", 1'b1, 32'hBBBB_BBBB, 2'b00);
        fetch1(0, 64'd1, "rst_keep_u0", 32'h0070_0083, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memoria_instrucao_sinc.md
MEMORIA_INSTRUCAO_SINC -- requirements
Module: memoria_instrucao_sinc

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words (power of two, 16..1024).
REQ-002 SHALL have parameter PC_W, default 64, width of the fetch address.
REQ-003 SHALL have parameter BYTE_ADDR, default 0: 0 = pc is a word index; 1 = pc is a byte address, word index = pc>>2.
REQ-004 SHALL have parameter LATENCY, default 1, cycles from accepted fetch to response (1..4).
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port fetch_req, input, 1, fetch request.
REQ-008 SHALL have port pc, input, PC_W, fetch address.
REQ-009 SHALL have port fetch_ready, output, 1, high when a fetch can be accepted.
REQ-010 SHALL have port flush, input, 1, discards all in-flight fetches.
REQ-011 SHALL have port instr_valid, output, 1, one-cycle strobe marking a response.
REQ-012 SHALL have port instrucao, output, 32, fetched instruction.
REQ-013 SHALL have port fault, output, 2, response status: 00 ok, 01 out of range, 10 misaligned.
REQ-014 SHALL have port prog_en, input, 1, programming mode.
REQ-015 SHALL have ports prog_we (input, 1), prog_addr (input, clog2(DEPTH)) and prog_data (input, 32): write port.

Function
REQ-016 SHALL accept a fetch in a cycle when fetch_req and fetch_ready are both high; at most one fetch is accepted per cycle.
REQ-017 SHALL hold fetch_ready = !prog_en.
REQ-018 SHALL assert instr_valid exactly LATENCY cycles after acceptance; back-to-back fetches give back-to-back responses in order.
REQ-019 SHALL deliver rom[index] with fault=00 when the index is below DEPTH and the address is aligned.
REQ-020 SHALL deliver instrucao=0 (NOP) with fault=01 when the index is at or above DEPTH, comparing the full PC_W value with no truncation or wrap-around.
REQ-021 SHALL, with BYTE_ADDR=1 and pc[1:0]!=0, deliver instrucao=0 with fault=10; misalignment takes priority over out of range.
REQ-022 SHALL hold instrucao=0 and fault=00 whenever instr_valid is low.
REQ-023 SHALL write prog_data to rom[prog_addr] at the clock edge where prog_en and prog_we are both high; prog_we without prog_en is ignored.
REQ-024 SHALL, for a write and an in-flight read of the same word in the same cycle, return the pre-write data (read-before-write).
REQ-025 SHALL let fetches accepted before prog_en rose complete normally while prog_en is high.
REQ-026 SHALL, on flush, clear all in-flight fetches: no instr_valid occurs for fetches accepted before or in the flush cycle.
REQ-027 SHALL accept a fetch presented in the cycle after flush.
REQ-028 SHALL initialise every ROM word to 0 at time zero.

Reset
REQ-029 SHALL, while rst_n is low, force instr_valid=0, instrucao=0 and fault=00 immediately and clear the latency pipeline.
REQ-030 SHALL leave ROM contents unchanged on reset.
REQ-031 SHALL discard fetches in flight when reset asserts; none produce a response after reset releases.
REQ-032 SHALL accept fetches from the first rising edge after rst_n deasserts, provided prog_en=0.

Verification
REQ-033 Program rom[1]=0x00700083 with DEPTH=64, LATENCY=1; fetch pc=1 -> next cycle instr_valid=1, instrucao=0x00700083, fault=00.
REQ-034 Fetch pc=64, then pc=2^63 -> instrucao=0, fault=01 for both; no aliasing to rom[0].
REQ-035 BYTE_ADDR=1: fetch pc=8 -> rom[2] with fault=00; fetch pc=6 -> instrucao=0 with fault=10.
REQ-036 LATENCY=3: fetch pc=0,1,2 on consecutive cycles -> valid strobes in cycles 3,4,5, in order; flush in cycle 2 -> no responses.
REQ-037 prog_en=1 -> fetch_ready=0 and fetch_req ignored; write rom[5] while a fetch of pc=5 is in flight -> old value returned; a later fetch returns the new value.
REQ-038 Assert rst_n low with 2 fetches in flight (LATENCY=3) -> instr_valid stays 0 after release; previously programmed ROM words read back intact.
